// File: rtl/piso_tx_sequencer.sv
// Sequences an external PISO shift register as a timed serial transmitter:
// accepts words on valid/ready, holds each bit CLKS_PER_BIT cycles, supports gapless words.
module piso_tx_sequencer #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          COVER        = 1'b0
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [WIDTH-1:0]                             data_i,
    input  logic                                         valid_i,
    output logic                                         ready_o,
    output logic                                         set_o,
    output logic [WIDTH-1:0]                             value_o,
    output logic                                         advance_o,
    output logic                                         bit_strobe_o,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] bit_index_o,
    output logic                                         busy_o,
    output logic                                         done_o
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DivW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q;
    logic [DivW-1:0] div_q;
    logic [IdxW-1:0] idx_q;

    logic div_wrap;
    logic last_bit;

    assign div_wrap = (div_q == DivLast);
    assign last_bit = (idx_q == IdxLast);

    assign busy_o       = (state_q == StShift);
    // The final cycle of a word may accept the next one so bit 0 follows without a gap.
    assign ready_o      = !rst_i && (!busy_o || (div_wrap && last_bit));
    assign set_o        = valid_i && ready_o;
    assign value_o      = data_i;
    assign advance_o    = busy_o && div_wrap && !last_bit;
    assign done_o       = busy_o && div_wrap && last_bit;
    assign bit_strobe_o = busy_o && (div_q == '0);
    assign bit_index_o  = idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            div_q   <= '0;
            idx_q   <= '0;
        end else if (set_o) begin
            state_q <= StShift;
            div_q   <= '0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    div_q <= '0;
                    idx_q <= '0;
                end
                StShift: begin
                    if (div_wrap) begin
                        div_q <= '0;
                        if (last_bit) begin
                            state_q <= StIdle;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    if (COVER) begin : g_cover
        cover property (@(posedge clk_i) disable iff (rst_i) done_o && set_o);
        cover property (@(posedge clk_i) disable iff (rst_i) done_o && !set_o);
    end

endmodule

// File: doc/piso_tx_sequencer.md
# piso_tx_sequencer

Controller that sequences a `shift_register_piso` instance as a timed serial transmitter. It accepts parallel words over a valid/ready handshake and drives the register's `set_i`/`value_i`/`advance_i`. Each bit is held on the register's `bit_o` for `CLKS_PER_BIT` cycles, and the sequencer flags bit boundaries and word completion. It sits between a word source (FIFO or CSR) and the serial line driver, and supports gapless back-to-back words.

## Interface
- `WIDTH`, 8, word width; must match the driven shift register; ≥2.
- `CLKS_PER_BIT`, 4, cycles each bit is held; ≥1.
- `COVER`, 0, formal-only; 1 enables cover properties.

- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `data_i`  in  WIDTH  word to transmit, LSB first.
- `valid_i`  in  1  `data_i` valid.
- `ready_o`  out  1  sequencer can accept a word this cycle.
- `set_o`  out  1  to shift register `set_i`.
- `value_o`  out  WIDTH  to shift register `value_i`; combinationally equal to `data_i`.
- `advance_o`  out  1  to shift register `advance_i`.
- `bit_strobe_o`  out  1  one-cycle pulse in the first cycle each new bit is present on `bit_o`.
- `bit_index_o`  out  max(1,$clog2(WIDTH))  index of the bit currently on `bit_o`.
- `busy_o`  out  1  a word is being shifted.
- `done_o`  out  1  one-cycle pulse in the final cycle of a word.

## Operation
- **States:** IDLE, SHIFT.
- **Counters:**
  - `div`: 0..CLKS_PER_BIT-1, width max(1,$clog2(CLKS_PER_BIT)).
  - `bit_index`: 0..WIDTH-1.
- **Accept:** a handshake occurs when `valid_i && ready_o`.
  - `set_o = valid_i && ready_o`, combinational.
  - On a handshake: state becomes SHIFT, `div`=0, `bit_index`=0.
- **ready_o:**
  - 1 in IDLE.
  - 1 in SHIFT only during the last cycle (`div`=CLKS_PER_BIT-1 and `bit_index`=WIDTH-1).
  - 0 otherwise, and 0 whenever `rst_i` is high.
- **SHIFT:**
  - `div` increments each cycle and wraps to 0 at CLKS_PER_BIT-1.
  - On a wrap with `bit_index`<WIDTH-1: `advance_o`=1 and `bit_index` increments.
  - `advance_o` is never asserted on the last bit.
- **Last cycle of a word:**
  - `done_o`=1.
  - If a handshake occurs, reload and stay in SHIFT. The register's set-precedence makes the new bit 0 appear without a gap.
  - Otherwise go to IDLE. The shift register then holds 0 on `bit_o`, since all bits have shifted out.
- **Derived outputs:**
  - `busy_o` = (state==SHIFT).
  - `bit_strobe_o` = busy_o && `div`==0.
  - `bit_index_o` = `bit_index`; it reads 0 in IDLE.
- **CLKS_PER_BIT=1:** `advance_o` is high in every SHIFT cycle except the last bit; `bit_strobe_o` is high in every SHIFT cycle.
- **valid_i without ready_o:** ignored. `data_i` need not be held stable after acceptance.
- **Reset mid-word:** the word is abandoned; no `done_o` is emitted. `rst_i` also resets the shift register, since the two share the reset.

## Timing
- **Reset:** during `rst_i` and in the cycle after it:
  - State is IDLE, `div`=0, `bit_index`=0.
  - `set_o`=0, `advance_o`=0, `busy_o`=0, `done_o`=0, `bit_strobe_o`=0, `bit_index_o`=0.
  - `ready_o`=0 during reset and 1 in the first cycle after it.
- **Word timeline:** for a handshake in cycle k, with C=CLKS_PER_BIT and W=WIDTH:
  - Bit n is on `bit_o` in cycles k+1+n·C through k+(n+1)·C.
  - `bit_strobe_o` is high in cycles k+1+n·C.
  - `advance_o` is high in cycles k+(n+1)·C for n<W-1.
  - `done_o` is high in cycle k+W·C.
- **Throughput:** latency from handshake to bit 0 on the line is 1 cycle. Sustained throughput is one word per W·C cycles with no idle cycle between words.
- **Outputs:** all outputs except `set_o`, `value_o` and `ready_o` are functions of registered state only.

## Test plan
- **Single word:** W=8, C=4; `data_i`=0xA5 accepted at cycle 10 → `bit_o` sequence 1,0,1,0,0,1,0,1, each bit held 4 cycles from cycle 11. `bit_strobe_o` at 11,15,…,39. `advance_o` at 14,18,…,38 (7 pulses). `done_o` only at 42. `ready_o` at 42 and from 43 onward.
- **Back-to-back:** `valid_i` held high with 0x01 then 0x80 → second word accepted at cycle k+32. No gap on `bit_o`. Two `done_o` pulses, 32 cycles apart. `busy_o` stays 1 throughout.
- **Backpressure:** `valid_i` raised mid-word → `set_o` stays 0 and the word is not accepted until the last-bit cycle. `data_i` changes while not ready → no effect.
- **C=1, W=4:** 0b1101 → `bit_o` reads 1,0,1,1 on consecutive cycles. `advance_o` on 3 cycles. `done_o` on the 4th cycle.
- **Reset mid-word:** `rst_i` pulsed 1 cycle during bit 3 → next cycle: IDLE, `busy_o`=0, `bit_o`=0, no `done_o`. A new word is then accepted normally.
